object_spawn_scheduler: RTL and testbench

- Allocates spawn requests to a pool of NUM_SLOTS object position controllers.
- Accepts one spawn descriptor per valid/ready handshake and chooses a free slot round-robin.
- Broadcasts the descriptor on a shared config bus, pulses that slot's sync line low to load it, then confirms the slot left the free state.
- Sits between the pattern/sequence ROM reader and the bank of object position controllers.

---
 rtl/object_spawn_scheduler.sv | 146 ++++++++++++++
 tb/tb_object_spawn_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_spawn_scheduler.sv
// rtl/object_spawn_scheduler.sv - round-robin allocator loading spawn descriptors into object controller slots
// Latches one descriptor, picks a free slot from rr_ptr, pulses its sync line low, then waits for the slot to go busy.
module object_spawn_scheduler #(
  parameter int NUM_SLOTS   = 8,
  parameter int SLOT_BITS   = 3,
  parameter int LOAD_CYCLES = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk_object_control,
  input  logic                 reset,
  input  logic                 spawn_valid,
  output logic                 spawn_ready,
  input  logic [2:0]           spawn_direction,
  input  logic [9:0]           spawn_pos_x,
  input  logic [9:0]           spawn_pos_y,
  input  logic [9:0]           spawn_w,
  input  logic [9:0]           spawn_h,
  input  logic [4:0]           spawn_speed,
  input  logic [7:0]           spawn_destroy_time,
  input  logic [1:0]           spawn_destroy_trigger,
  input  logic [NUM_SLOTS-1:0] slot_free,
  output logic [NUM_SLOTS-1:0] slot_sync,
  output logic [2:0]           cfg_direction,
  output logic [9:0]           cfg_pos_x,
  output logic [9:0]           cfg_pos_y,
  output logic [9:0]           cfg_w,
  output logic [9:0]           cfg_h,
  output logic [4:0]           cfg_speed,
  output logic [7:0]           cfg_destroy_time,
  output logic [1:0]           cfg_destroy_trigger,
  output logic [SLOT_BITS:0]   active_slot_count,
  output logic [SLOT_BITS-1:0] last_slot,
  output logic                 load_error
);

  typedef enum logic [1:0] {IDLE, SEARCH, LOAD, WAIT_ACK} state_t;

  state_t               state, state_next;
  logic [SLOT_BITS-1:0] rr_ptr, sel, scan_idx, scan_sel;
  logic                 scan_found;
  logic [7:0]           cnt;
  logic [SLOT_BITS:0]   busy_count;
  logic                 accept, load_done, ack_seen, ack_timeout;

  assign accept      = (state == IDLE) && spawn_valid && spawn_ready;
  assign load_done   = (state == LOAD) && (cnt == 8'(LOAD_CYCLES - 1));
  assign ack_seen    = !slot_free[sel];
  assign ack_timeout = (cnt == 8'(ACK_TIMEOUT - 1));

  // First free slot at or after rr_ptr, wrapping modulo NUM_SLOTS.
  always_comb begin
    scan_found = 1'b0;
    scan_sel   = rr_ptr;
    scan_idx   = rr_ptr;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      scan_idx = rr_ptr + SLOT_BITS'(i);
      if (!scan_found && slot_free[scan_idx]) begin
        scan_found = 1'b1;
        scan_sel   = scan_idx;
      end
    end
  end

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_free[i]) busy_count = busy_count + {{SLOT_BITS{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_object_control or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = SEARCH;
      SEARCH:   if (scan_found) state_next = LOAD;
      LOAD:     if (load_done) state_next = WAIT_ACK;
      WAIT_ACK: if (ack_seen || ack_timeout) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // cnt times the sync pulse in LOAD and the ack window in WAIT_ACK; cleared on entry to each.
  always_ff @(posedge clk_object_control or negedge reset) begin
    if (!reset) begin
      spawn_ready         <= 1'b0;
      slot_sync           <= '1;
      cfg_direction       <= '0;
      cfg_pos_x           <= '0;
      cfg_pos_y           <= '0;
      cfg_w               <= '0;
      cfg_h               <= '0;
      cfg_speed           <= '0;
      cfg_destroy_time    <= '0;
      cfg_destroy_trigger <= '0;
      active_slot_count   <= '0;
      last_slot           <= '0;
      rr_ptr              <= '0;
      sel                 <= '0;
      cnt                 <= '0;
      load_error          <= 1'b0;
    end else begin
      active_slot_count <= busy_count;
      spawn_ready       <= (state == IDLE) && !accept && (|slot_free);
      if (accept) begin
        cfg_direction       <= spawn_direction;
        cfg_pos_x           <= spawn_pos_x;
        cfg_pos_y           <= spawn_pos_y;
        cfg_w               <= spawn_w;
        cfg_h               <= spawn_h;
        cfg_speed           <= spawn_speed;
        cfg_destroy_time    <= spawn_destroy_time;
        cfg_destroy_trigger <= spawn_destroy_trigger;
      end
      case (state)
        SEARCH: begin
          if (scan_found) begin
            sel       <= scan_sel;
            slot_sync <= ~({{(NUM_SLOTS-1){1'b0}}, 1'b1} << scan_sel);
            cnt       <= '0;
          end
        end
        LOAD: begin
          if (load_done) begin
            slot_sync <= '1;
            last_slot <= sel;
            rr_ptr    <= sel + SLOT_BITS'(1);
            cnt       <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_ACK: begin
          cnt <= cnt + 8'd1;
          if (!ack_seen && ack_timeout) load_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_object_spawn_scheduler.sv
// tb/tb_object_spawn_scheduler.sv - scoreboard bench for object_spawn_scheduler
// Stimulus pushes expected loads from a slot-pool model; a monitor pops them as sync pulses appear.
module tb_object_spawn_scheduler;
  localparam int N  = 8;
  localparam int LC = 2;
  localparam int AT = 16;

  typedef struct {
    logic [2:0] slot;
    logic [2:0] dir;
    logic [9:0] x, y, w, h;
    logic [4:0] spd;
    logic [7:0] dt;
    logic [1:0] trig;
    int         acc;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, spawn_valid, spawn_ready, load_error;
  logic [2:0] spawn_direction, cfg_direction, last_slot;
  logic [9:0] spawn_pos_x, spawn_pos_y, spawn_w, spawn_h;
  logic [9:0] cfg_pos_x, cfg_pos_y, cfg_w, cfg_h;
  logic [4:0] spawn_speed, cfg_speed;
  logic [7:0] spawn_destroy_time, cfg_destroy_time, slot_free, slot_sync;
  logic [1:0] spawn_destroy_trigger, cfg_destroy_trigger;
  logic [3:0] active_slot_count;

  object_spawn_scheduler #(.NUM_SLOTS(N), .SLOT_BITS(3), .LOAD_CYCLES(LC), .ACK_TIMEOUT(AT)) dut (
    .clk_object_control(clk), .reset(reset),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_direction(spawn_direction), .spawn_pos_x(spawn_pos_x), .spawn_pos_y(spawn_pos_y),
    .spawn_w(spawn_w), .spawn_h(spawn_h), .spawn_speed(spawn_speed),
    .spawn_destroy_time(spawn_destroy_time), .spawn_destroy_trigger(spawn_destroy_trigger),
    .slot_free(slot_free), .slot_sync(slot_sync),
    .cfg_direction(cfg_direction), .cfg_pos_x(cfg_pos_x), .cfg_pos_y(cfg_pos_y),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_speed(cfg_speed),
    .cfg_destroy_time(cfg_destroy_time), .cfg_destroy_trigger(cfg_destroy_trigger),
    .active_slot_count(active_slot_count), .last_slot(last_slot), .load_error(load_error)
  );

  int    n_tests = 0;
  int    n_fails = 0;
  int    cyc = 0;
  int    rise_cyc = 0;
  int    rr_model = 0;
  bit    err_model = 1'b0;
  bit    ack_on = 1'b1;
  item_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick_slot(input int rr, input logic [7:0] free);
    for (int k = 0; k < N; k++) if (free[(rr + k) % N]) return (rr + k) % N;
    return 0;
  endfunction

  function automatic int busy_of(input logic [7:0] free);
    int c = 0;
    for (int k = 0; k < N; k++) if (!free[k]) c++;
    return c;
  endfunction

  function automatic logic [63:0] desc_of(input item_t d);
    return 64'({d.dir, d.x, d.y, d.w, d.h, d.spd, d.dt, d.trig});
  endfunction

  // Controller model: a slot whose sync line is low latches and goes busy.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ack_on) for (int n = 0; n < N; n++) if (slot_sync[n] == 1'b0) slot_free[n] = 1'b0;
  endtask

  task automatic settle();
    repeat (4 + LC + AT) tick();
  endtask

  task automatic check_count();
    check("active_count", 64'(active_slot_count), 64'(busy_of(slot_free)));
  endtask

  task automatic spawn(input item_t d);
    int waited = 0;
    spawn_direction = d.dir; spawn_pos_x = d.x; spawn_pos_y = d.y; spawn_w = d.w; spawn_h = d.h;
    spawn_speed = d.spd; spawn_destroy_time = d.dt; spawn_destroy_trigger = d.trig;
    spawn_valid = 1'b1;
    while (spawn_ready !== 1'b1 && waited < 300) begin
      tick();
      waited++;
    end
    if (spawn_ready !== 1'b1) begin
      check("spawn_accept_wait", 64'(spawn_ready), 64'(1));
      spawn_valid = 1'b0;
      return;
    end
    d.slot = 3'(pick_slot(rr_model, slot_free));
    d.acc  = cyc;
    exp_q.push_back(d);
    rr_model = (int'(d.slot) + 1) % N;
    if (!ack_on) err_model = 1'b1;
    tick();
    spawn_valid = 1'b0;
  endtask

  task automatic spawn_rand();
    item_t d;
    logic [31:0] r1, r2;
    r1 = $urandom(); r2 = $urandom();
    d.dir = r1[2:0]; d.x = r1[12:3]; d.y = r1[22:13]; d.w = r2[9:0]; d.h = r2[19:10];
    d.spd = r2[24:20]; d.dt = {r1[31:28], r2[28:25]}; d.trig = r2[30:29];
    d.slot = '0; d.acc = 0;
    spawn(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    rr_model = 0;
    err_model = 1'b0;
  endtask

  initial begin
    reset = 1'b0; spawn_valid = 1'b0; slot_free = 8'hFF;
    spawn_direction = '0; spawn_pos_x = '0; spawn_pos_y = '0; spawn_w = '0; spawn_h = '0;
    spawn_speed = '0; spawn_destroy_time = '0; spawn_destroy_trigger = '0;
    fork
      begin : stim
        item_t d;
        logic [31:0] r;
        int err_cyc;
        tick(); tick();
        check("rst_sync", 64'(slot_sync), 64'(8'hFF));
        check("rst_ready", 64'(spawn_ready), 64'(0));
        check("rst_count", 64'(active_slot_count), 64'(0));
        check("rst_last_slot", 64'(last_slot), 64'(0));
        check("rst_error", 64'(load_error), 64'(0));
        check("rst_cfg", 64'({cfg_direction, cfg_pos_x, cfg_pos_y, cfg_w, cfg_h, cfg_speed,
                              cfg_destroy_time, cfg_destroy_trigger}), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("ready_after_reset", 64'(spawn_ready), 64'(1));

        d.dir = 3'd2; d.x = 10'd100; d.y = 10'd200; d.w = 10'd16; d.h = 10'd16;
        d.spd = 5'd8; d.dt = 8'd10; d.trig = 2'd1; d.slot = '0; d.acc = 0;
        spawn(d);
        settle();
        check_count();
        check("first_last_slot", 64'(last_slot), 64'(0));

        // Nine back-to-back spawns into a pool that never frees.
        do_reset();
        slot_free = 8'hFF;
        repeat (8) spawn_rand();
        settle();
        check("full_ready", 64'(spawn_ready), 64'(0));
        check("full_count", 64'(active_slot_count), 64'(8));
        check("full_last_slot", 64'(last_slot), 64'(7));
        spawn_valid = 1'b1;
        repeat (5) begin
          tick();
          check("ninth_blocked", 64'(spawn_ready), 64'(0));
        end
        slot_free[3] = 1'b1;
        spawn_rand();
        settle();
        check("ninth_last_slot", 64'(last_slot), 64'(3));
        check_count();

        // rr_ptr reaches 7, then wraps to slot 0.
        slot_free = 8'h40;
        spawn_rand();
        settle();
        slot_free = 8'h81;
        spawn_rand();
        spawn_rand();
        settle();
        check("wrap_last_slot", 64'(last_slot), 64'(0));

        // Slot never acknowledges: sticky error after the ack window.
        ack_on = 1'b0;
        slot_free = 8'h02;
        spawn_rand();
        err_cyc = -1;
        for (int k = 0; k < 60; k++) begin
          if (load_error === 1'b1) begin
            err_cyc = cyc;
            break;
          end
          tick();
        end
        check("timeout_latency", 64'(err_cyc), 64'(rise_cyc + AT));
        settle();
        check("timeout_idle", 64'(spawn_ready), 64'(1));
        ack_on = 1'b1;
        slot_free[2] = 1'b1;
        spawn_rand();
        settle();
        check("after_timeout_slot", 64'(last_slot), 64'(2));
        check("error_sticky", 64'(load_error), 64'(1));

        // Reset in the middle of a load pulse.
        slot_free = 8'hFF;
        spawn_rand();
        for (int k = 0; k < 10 && slot_sync === 8'hFF; k++) tick();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_in_load_sync", 64'(slot_sync), 64'(8'hFF));
        check("reset_in_load_ready", 64'(spawn_ready), 64'(0));
        tick(); tick();
        slot_free = 8'hFF;
        reset = 1'b1;
        rr_model = 0;
        err_model = 1'b0;
        tick();
        check("reset_clears_error", 64'(load_error), 64'(0));
        check("ready_after_reset2", 64'(spawn_ready), 64'(1));

        for (int i = 0; i < 25; i++) begin
          r = $urandom();
          if (r[1:0] == 2'd0) slot_free = slot_free | r[15:8];
          if (slot_free == 8'h00) slot_free[r[18:16]] = 1'b1;
          ack_on = (r[22:20] != 3'd0);
          spawn_rand();
          settle();
          if (r[3]) check_count();
        end
        ack_on = 1'b1;
        settle();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("final_error", 64'(load_error), 64'(err_model));
      end
      begin : mon
        item_t       cur;
        int          low_cnt;
        bit          in_load;
        logic [7:0]  exp_sync;
        low_cnt = 0;
        in_load = 1'b0;
        cur.slot = '0;
        exp_sync = 8'hFF;
        forever begin
          @(negedge clk);
          if (reset !== 1'b1) begin
            in_load = 1'b0;
            low_cnt = 0;
          end else if (slot_sync !== 8'hFF) begin
            if (!in_load) begin
              if (exp_q.size() == 0) begin
                check("unexpected_load", 64'(slot_sync), 64'(8'hFF));
              end else begin
                cur = exp_q.pop_front();
                in_load = 1'b1;
                low_cnt = 1;
                exp_sync = ~(8'h01 << cur.slot);
                check("sync_pattern", 64'(slot_sync), 64'(exp_sync));
                check("sync_latency", 64'(cyc), 64'(cur.acc + 2));
                check("cfg_bus", 64'({cfg_direction, cfg_pos_x, cfg_pos_y, cfg_w, cfg_h, cfg_speed,
                                      cfg_destroy_time, cfg_destroy_trigger}), desc_of(cur));
              end
            end else begin
              low_cnt++;
              check("sync_hold", 64'(slot_sync), 64'(exp_sync));
              check("cfg_stable", 64'({cfg_direction, cfg_pos_x, cfg_pos_y, cfg_w, cfg_h, cfg_speed,
                                       cfg_destroy_time, cfg_destroy_trigger}), desc_of(cur));
            end
          end else if (in_load) begin
            in_load = 1'b0;
            rise_cyc = cyc;
            check("load_cycles", 64'(low_cnt), 64'(LC));
            check("last_slot", 64'(last_slot), 64'(cur.slot));
          end
        end
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end
endmodule
